ex_add_sched: RTL
=================

Name: ex_add_sched

Overview:
- Round-robin scheduler that shares the single execute-stage 32-bit adder between three requesters: 0 = ALU add/addi/lui/auipc, 1 = branch-target generation, 2 = LSU address generation.
- Requesters present operands that are already muxed (immediate/PC selection is done upstream). The block arbitrates among them, performs the add and registers the result.
- The result is returned with a requester id and tag over a valid/ready output channel.
- Sits between decode/dispatch operand delivery and writeback/LSU/branch resolution.

Parameters:
- XLEN, 32, operand and result width (matches CpuType).
- NREQ, 3, number of requesters (2..8).
- TAGW, 4, per-request tag width, returned unchanged.
- CNTW, 16, width of the saturating contention counter.

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  asynchronous reset, active low.
- iReqValid  in  NREQ  per-requester request valid.
- iReqA  in  NREQ*XLEN  operand A; slice i belongs to requester i.
- iReqB  in  NREQ*XLEN  operand B; slice i belongs to requester i.
- iReqTag  in  NREQ*TAGW  request tags; slice i belongs to requester i.
- oReqGrant  out  NREQ  one-hot grant; the request is accepted in the same cycle.
- oResValid  out  1  result register holds valid data.
- oResult  out  XLEN  A+B, modulo 2^XLEN.
- oResSrc  out  clog2(NREQ)  index of the granted requester.
- oResTag  out  TAGW  tag of the granted request.
- iResReady  in  1  consumer accepts the result.
- iFlush  in  1  pipeline flush; drops the held result.
- oContendCnt  out  CNTW  number of cycles in which a valid request was not granted.

Behaviour:
- Reset (async, iRst_n=0): oResValid=0, oResult=0, oResSrc=0, oResTag=0, oContendCnt=0, RR pointer=0. oReqGrant=0 while reset is asserted.
- Requester rule: once iReqValid[i] is asserted, A/B/Tag for slice i must stay stable until oReqGrant[i]=1.
  - Deasserting valid before grant is legal (the request is cancelled).
  - The bench flags any operand change while valid and not granted.
- Slot free condition: canAccept = !oResValid | iResReady. This is a combinational ready-to-grant path and is intended.
- Grant rule: if canAccept and !iFlush and |iReqValid, grant exactly one requester.
  - Search starts at the RR pointer and proceeds upward with wrap-around.
  - oReqGrant is combinational from the current inputs and state.
  - With no eligible request, oReqGrant=0.
- RR pointer: after a grant to requester i, pointer becomes (i+1) mod NREQ. It holds when there is no grant and is unchanged by flush.
- Result register, updated on the rising edge:
  - Grant: oResult <= A_i+B_i (carry out discarded), oResSrc<=i, oResTag<=Tag_i, oResValid<=1. Latency is 1 cycle from grant to oResValid.
  - No grant, oResValid & iResReady: oResValid<=0. Data fields hold their last value.
  - No grant and stalled (oResValid & !iResReady): all fields hold.
- Flush: iFlush=1 forces oResValid<=0 on the next edge. No grant is issued that cycle, and flush wins over a simultaneous grant.
  - A result presented while iFlush=1 is still consumed if iResReady=1; the consumer ignores it.
- Back-to-back operation: with iResReady held at 1, one result per cycle (full throughput).
- Contention counter: increments by 1 each cycle in which |iReqValid & !(|oReqGrant) & !iFlush.
  - Also increments by 1 in a cycle where more than one request is valid (popcount>1) and one is granted; it never adds more than 1 per cycle.
  - Saturates at 2^CNTW-1. Cleared only by reset.
- Reset asserted mid-operation: the held result is lost, the pointer returns to 0, and there is no partial output.
- NREQ=2 must work; for NREQ that is not a power of 2, pointer wrap goes NREQ-1 -> 0.
- No state machine beyond the RR pointer, the result-valid flag and the counter. There are no X-propagating outputs after reset.

Decomposition:
- Shared package (ZionDataType or an ex package): CpuType (XLEN), an ExAddReq_s struct {A,B,Tag} and the requester index enum (REQ_ALU=0, REQ_BR=1, REQ_LSU=2).
- One natural sub-module, rr_arbiter: a parameterised NREQ round-robin arbiter.
  - Inputs: request vector, enable, pointer.
  - Outputs: one-hot grant and the encoded index.
  - Reusable by other shared units.
- The adder is inline in ex_add_sched; no separate module is needed.

Test Plan:
- Single request, from reset: cycle 1 iReqValid=001, A=0x0000_1000, B=0x0000_0234, Tag=5, iResReady=1 -> oReqGrant=001 in cycle 1; cycle 2 oResValid=1, oResult=0x0000_1234, oResSrc=0, oResTag=5.
- Fairness: all three requesters held valid with iResReady=1 for 6 cycles -> grants in order 0,1,2,0,1,2; oContendCnt=6.
- Backpressure: result held and iResReady=0 for 3 cycles while req1 valid -> oReqGrant=0 and oResult stable for 3 cycles; on the cycle iResReady=1, req1 is granted in that same cycle and its result appears on the next edge.
- Wrap and overflow: A=0xFFFF_FFFF, B=0x0000_0002 -> oResult=0x0000_0001 with no error indication. Separately, after a grant to req2, a new req0 and req1 together -> req0 is granted (pointer wrapped to 0).
- Flush: result valid while iFlush=1 and req0 valid in the same cycle -> no grant; next cycle oResValid=0, pointer unchanged; req0 is granted the cycle after.
- Async reset mid-stall: iRst_n pulled low between clock edges while oResValid=1 and stalled -> oResValid=0 and oContendCnt=0 immediately, without waiting for an edge. After release, first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/ex_add_sched_pkg.sv
// Shared types and defaults for the execute-stage adder scheduler.
// Requester numbering, request struct and the index-width helper live here.
package ex_add_sched_pkg;

    localparam int XLEN = 32;
    localparam int NREQ = 3;
    localparam int TAGW = 4;
    localparam int CNTW = 16;

    typedef logic [XLEN-1:0] CpuType;

    typedef struct packed {
        CpuType          A;
        CpuType          B;
        logic [TAGW-1:0] Tag;
    } ExAddReq_s;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_BR  = 2'd1,
        REQ_LSU = 2'd2
    } ex_add_req_e;

    // Index width that stays at least one bit wide.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ex_add_sched_if.sv
// Request/result bundle between dispatch operand delivery and the adder scheduler.
// Slice i of each packed request field belongs to requester i.
interface ex_add_sched_if #(
    parameter int NREQ = ex_add_sched_pkg::NREQ,
    parameter int XLEN = ex_add_sched_pkg::XLEN,
    parameter int TAGW = ex_add_sched_pkg::TAGW,
    parameter int CNTW = ex_add_sched_pkg::CNTW,
    parameter int SRCW = ex_add_sched_pkg::idx_w(NREQ)
);
    logic [NREQ-1:0]           iReqValid;
    logic [NREQ-1:0][XLEN-1:0] iReqA;
    logic [NREQ-1:0][XLEN-1:0] iReqB;
    logic [NREQ-1:0][TAGW-1:0] iReqTag;
    logic [NREQ-1:0]           oReqGrant;
    logic                      oResValid;
    logic [XLEN-1:0]           oResult;
    logic [SRCW-1:0]           oResSrc;
    logic [TAGW-1:0]           oResTag;
    logic                      iResReady;
    logic                      iFlush;
    logic [CNTW-1:0]           oContendCnt;

    modport master (
        output iReqValid, iReqA, iReqB, iReqTag, iResReady, iFlush,
        input  oReqGrant, oResValid, oResult, oResSrc, oResTag, oContendCnt
    );

    modport slave (
        input  iReqValid, iReqA, iReqB, iReqTag, iResReady, iFlush,
        output oReqGrant, oResValid, oResult, oResSrc, oResTag, oContendCnt
    );
endinterface

// File: rtl/ex_add_sched_rr_arbiter.sv
// Parameterised round-robin arbiter: searches upward from ptr with wrap-around
// and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IDXW = ex_add_sched_pkg::idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx
);
    logic            found;
    int              cand;
    logic [IDXW-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Wrap explicitly so non-power-of-two NREQ goes NREQ-1 -> 0.
            cand = int'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = IDXW'(cand);
            if (en && !found && req[cand_idx]) begin
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_add_sched.sv
// Shares one execute-stage adder among NREQ requesters (ALU, branch target, LSU AGU):
// round-robin grant, registered sum with id/tag, valid/ready result, flush and contention count.
module ex_add_sched #(
    parameter int NREQ = ex_add_sched_pkg::NREQ,
    parameter int XLEN = ex_add_sched_pkg::XLEN,
    parameter int TAGW = ex_add_sched_pkg::TAGW,
    parameter int CNTW = ex_add_sched_pkg::CNTW
) (
    input logic         iClk,
    input logic         iRst_n,
    ex_add_sched_if.slave bus
);
    import ex_add_sched_pkg::*;

    localparam int SRCW = idx_w(NREQ);

    logic            can_accept, grant_en, any_gnt, multi_req, cnt_inc;
    logic [NREQ-1:0] gnt;
    logic [SRCW-1:0] gidx;

    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [SRCW-1:0] src_q, src_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [SRCW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Grant is held off while reset is asserted so nothing leaks out during reset.
    assign can_accept = !res_valid_q | bus.iResReady;
    assign grant_en   = iRst_n & can_accept & !bus.iFlush;

    rr_arbiter #(.NREQ(NREQ), .IDXW(SRCW)) u_arb (
        .req (bus.iReqValid),
        .en  (grant_en),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gidx)
    );

    assign any_gnt   = |gnt;
    assign multi_req = |(bus.iReqValid & (bus.iReqValid - NREQ'(1)));
    assign cnt_inc   = ((|bus.iReqValid) & !any_gnt & !bus.iFlush) | (multi_req & any_gnt);

    always_comb begin
        res_valid_d = res_valid_q;
        result_d    = result_q;
        src_d       = src_q;
        tag_d       = tag_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        if (any_gnt) begin
            result_d    = bus.iReqA[gidx] + bus.iReqB[gidx];
            src_d       = gidx;
            tag_d       = bus.iReqTag[gidx];
            res_valid_d = 1'b1;
            ptr_d       = (gidx == SRCW'(NREQ - 1)) ? '0 : gidx + SRCW'(1);
        end else if (bus.iFlush || bus.iResReady) begin
            res_valid_d = 1'b0;
        end
        if (cnt_inc && (cnt_q != '1)) cnt_d = cnt_q + CNTW'(1);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            res_valid_q <= 1'b0;
            result_q    <= '0;
            src_q       <= '0;
            tag_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            src_q       <= src_d;
            tag_q       <= tag_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.oReqGrant   = gnt;
    assign bus.oResValid   = res_valid_q;
    assign bus.oResult     = result_q;
    assign bus.oResSrc     = src_q;
    assign bus.oResTag     = tag_q;
    assign bus.oContendCnt = cnt_q;

endmodule
